// File: rtl/ahb_mem_arbiter_pkg.sv
// ahb_mem_arbiter_pkg: shared encodings for the two-master AHB-Lite memory arbiter
//   htrans_t      AHB HTRANS encodings
//   port_state_t  per-port IDLE/PEND/DATA state
//   ARB_RR/ARB_FIXED  values for the ARB_MODE parameter
package ahb_mem_arbiter_pkg;
  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_t;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_PEND = 2'b01, ST_DATA = 2'b10} port_state_t;
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
endpackage

// File: rtl/ahb_mem_arbiter_port.sv
// ahb_port_hold: one master port -- address-phase hold register, IDLE/PEND/DATA FSM, ready/rdata mux
//   clk, rst_n                     clock, async active-low reset
//   hsel/haddr/htrans1/hwrite/hsize/hready  master address phase (htrans1 = HTRANS[1])
//   grant                          arbiter grant (only asserted while pend and slave ready)
//   s_hreadyout, s_hrdata          slave response
//   hreadyout, hrdata              response to the master
//   pend, data                     state flags to the arbiter
//   hold_addr/hold_write/hold_size captured address phase replayed on the slave
module ahb_port_hold
  import ahb_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  htrans1,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic                  hready,
  input  logic                  grant,
  input  logic                  s_hreadyout,
  input  logic [31:0]           s_hrdata,
  output logic                  hreadyout,
  output logic [31:0]           hrdata,
  output logic                  pend,
  output logic                  data,
  output logic [ADDR_WIDTH-1:0] hold_addr,
  output logic                  hold_write,
  output logic [2:0]            hold_size
);
  port_state_t state;
  logic cap, free;
  // NONSEQ and SEQ both capture; IDLE/BUSY never do and see a zero-wait OKAY
  assign cap  = hsel & htrans1 & hready;
  // the hold register may only be overwritten once the previous transfer is gone
  assign free = (state == ST_IDLE) | ((state == ST_DATA) & s_hreadyout);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ST_IDLE;
      hold_addr  <= '0;
      hold_write <= 1'b0;
      hold_size  <= '0;
    end else begin
      state <= (state == ST_PEND) ? (grant ? ST_DATA : ST_PEND) :
               free ? (cap ? ST_PEND : ST_IDLE) : state;
      if (free && cap) begin
        hold_addr  <= haddr;
        hold_write <= hwrite;
        hold_size  <= hsize;
      end
    end
  assign pend      = state == ST_PEND;
  assign data      = state == ST_DATA;
  assign hreadyout = pend ? 1'b0 : data ? s_hreadyout : 1'b1;
  assign hrdata    = data ? s_hrdata : '0;
endmodule

// File: rtl/ahb_mem_arbiter.sv
// ahb_mem_arbiter: shares one AHB-Lite memory slave between masters M0 and M1
//   HCLK, HRESETn       clock, async active-low reset
//   Mx_*                master-side AHB-Lite slave port (x = 0, 1)
//   S_*                 slave-side AHB-Lite master port
//   ARB_MODE            ARB_RR (alternate on contention) or ARB_FIXED (M0 wins)
module ahb_mem_arbiter
  import ahb_mem_arbiter_pkg::*;
#(
  parameter int ARB_MODE   = ARB_RR,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  M0_HSEL,
  input  logic [ADDR_WIDTH-1:0] M0_HADDR,
  input  logic [1:0]            M0_HTRANS,
  input  logic                  M0_HWRITE,
  input  logic [2:0]            M0_HSIZE,
  input  logic [31:0]           M0_HWDATA,
  input  logic                  M0_HREADY,
  output logic                  M0_HREADYOUT,
  output logic [31:0]           M0_HRDATA,
  input  logic                  M1_HSEL,
  input  logic [ADDR_WIDTH-1:0] M1_HADDR,
  input  logic [1:0]            M1_HTRANS,
  input  logic                  M1_HWRITE,
  input  logic [2:0]            M1_HSIZE,
  input  logic [31:0]           M1_HWDATA,
  input  logic                  M1_HREADY,
  output logic                  M1_HREADYOUT,
  output logic [31:0]           M1_HRDATA,
  output logic                  S_HSEL,
  output logic [ADDR_WIDTH-1:0] S_HADDR,
  output logic [1:0]            S_HTRANS,
  output logic                  S_HWRITE,
  output logic [2:0]            S_HSIZE,
  output logic [31:0]           S_HWDATA,
  output logic                  S_HREADY,
  input  logic                  S_HREADYOUT,
  input  logic [31:0]           S_HRDATA
);
  logic [1:0] pend, data, gnt, hwr;
  logic [ADDR_WIDTH-1:0] ha0, ha1;
  logic [2:0] hs0, hs1;
  logic last_grant, pick0, unused;
  // SEQ is always reissued as NONSEQ, so HTRANS[0] carries no information here
  assign unused = M0_HTRANS[0] ^ M1_HTRANS[0];
  ahb_port_hold #(.ADDR_WIDTH(ADDR_WIDTH)) u_p0 (
    .clk(HCLK), .rst_n(HRESETn), .hsel(M0_HSEL), .haddr(M0_HADDR), .htrans1(M0_HTRANS[1]),
    .hwrite(M0_HWRITE), .hsize(M0_HSIZE), .hready(M0_HREADY), .grant(gnt[0]),
    .s_hreadyout(S_HREADYOUT), .s_hrdata(S_HRDATA), .hreadyout(M0_HREADYOUT), .hrdata(M0_HRDATA),
    .pend(pend[0]), .data(data[0]), .hold_addr(ha0), .hold_write(hwr[0]), .hold_size(hs0)
  );
  ahb_port_hold #(.ADDR_WIDTH(ADDR_WIDTH)) u_p1 (
    .clk(HCLK), .rst_n(HRESETn), .hsel(M1_HSEL), .haddr(M1_HADDR), .htrans1(M1_HTRANS[1]),
    .hwrite(M1_HWRITE), .hsize(M1_HSIZE), .hready(M1_HREADY), .grant(gnt[1]),
    .s_hreadyout(S_HREADYOUT), .s_hrdata(S_HRDATA), .hreadyout(M1_HREADYOUT), .hrdata(M1_HRDATA),
    .pend(pend[1]), .data(data[1]), .hold_addr(ha1), .hold_write(hwr[1]), .hold_size(hs1)
  );
  // M0 wins if alone, if fixed priority, or if M1 had the previous grant (last_grant=1)
  assign pick0  = pend[0] & (~pend[1] | (ARB_MODE == ARB_FIXED) | last_grant);
  // a new address phase can only be placed while the slave is accepting one
  assign gnt[0] = S_HREADYOUT & pick0;
  assign gnt[1] = S_HREADYOUT & pend[1] & ~pick0;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) last_grant <= 1'b1;
    else if (|gnt) last_grant <= gnt[1];
  assign S_HSEL   = |gnt;
  assign S_HTRANS = (|gnt) ? HT_NONSEQ : HT_IDLE;
  assign S_HADDR  = gnt[0] ? ha0 : gnt[1] ? ha1 : '0;
  assign S_HWRITE = gnt[0] ? hwr[0] : gnt[1] & hwr[1];
  assign S_HSIZE  = gnt[0] ? hs0 : gnt[1] ? hs1 : '0;
  assign S_HWDATA = data[0] ? M0_HWDATA : data[1] ? M1_HWDATA : '0;
  assign S_HREADY = S_HREADYOUT;
endmodule
